// File: rtl/adder_io_pkg.sv
// rtl/adder_io_pkg.sv - shared constants and button FSM encoding for the adder I/O stages
package adder_io_pkg;

   localparam int OPERAND_N     = 5;
   localparam int DB_CYCLES_DEF = 1000000;
   localparam int SYNC_STG_DEF  = 2;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

endpackage

// File: rtl/operand_input_ctrl_if.sv
// rtl/operand_input_ctrl_if.sv - raw switch/button inputs and debounced operand outputs
interface operand_input_ctrl_if #(
   parameter int N = adder_io_pkg::OPERAND_N
);
   logic [N-1:0] A_in;
   logic [N-1:0] B_in;
   logic         Button;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         sub;
   logic         btn_db;
   logic         upd;

   modport master (
      output A_in, B_in, Button,
      input  A, B, sub, btn_db, upd
   );

   modport slave (
      input  A_in, B_in, Button,
      output A, B, sub, btn_db, upd
   );
endinterface

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - STAGES x WIDTH flop synchroniser with synchronous reset
module sync_chain #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] stg_q [STAGES];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
      end else begin
         stg_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
      end
   end

   assign q_o = stg_q[STAGES-1];
endmodule

// File: rtl/operand_input_ctrl.sv
// rtl/operand_input_ctrl.sv - sync/debounce of operand switches and add/sub button
// HOLD_MODE_EN: sub follows the debounced button level instead of toggling per press.
module operand_input_ctrl
   import adder_io_pkg::*;
#(
   parameter int N         = OPERAND_N,
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int SYNC_STG  = SYNC_STG_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   operand_input_ctrl_if.slave  io
);
   localparam int             CW      = $clog2(DB_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

   logic [2*N-1:0] sw_s;
   logic           btn_s;

   sync_chain #(.WIDTH(2*N), .STAGES(SYNC_STG)) u_sync_sw (
      .clk_i (CLK), .rst_i (RST), .d_i ({io.A_in, io.B_in}), .q_o (sw_s)
   );

   sync_chain #(.WIDTH(1), .STAGES(SYNC_STG)) u_sync_btn (
      .clk_i (CLK), .rst_i (RST), .d_i (io.Button), .q_o (btn_s)
   );

   logic [2*N-1:0] sw_prev_q;
   logic [CW-1:0]  sw_cnt_q, sw_cnt_d;
   logic [N-1:0]   a_q, b_q;
   logic           sw_commit;

   always_comb begin
      sw_cnt_d = sw_cnt_q;
      if (sw_s != sw_prev_q)      sw_cnt_d = '0;
      else if (sw_cnt_q != CNT_MAX) sw_cnt_d = sw_cnt_q + 1'b1;
   end

   // Only a value that is still stable this cycle may commit; a late glitch restarts the count.
   assign sw_commit = (sw_cnt_q == CNT_MAX) && (sw_s == sw_prev_q) && (sw_s != {a_q, b_q});

   always_ff @(posedge CLK) begin
      if (RST) begin
         sw_prev_q <= '0;
         sw_cnt_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         sw_prev_q <= sw_s;
         sw_cnt_q  <= sw_cnt_d;
         if (sw_commit) {a_q, b_q} <= sw_s;
      end
   end

   btn_state_e    state_q;
   logic [CW-1:0] bt_cnt_q;
   logic          btn_db_q;
   logic          press_evt, release_evt, mode_evt, sub_w;

   assign press_evt   = (state_q == PRESS_WAIT)   &&  btn_s && (bt_cnt_q == CNT_MAX);
   assign release_evt = (state_q == RELEASE_WAIT) && !btn_s && (bt_cnt_q == CNT_MAX);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         bt_cnt_q <= '0;
         btn_db_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               bt_cnt_q <= '0;
               if (btn_s) state_q <= PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  state_q  <= IDLE;
                  bt_cnt_q <= '0;
               end else if (press_evt) begin
                  state_q  <= PRESSED;
                  bt_cnt_q <= '0;
                  btn_db_q <= 1'b1;
               end else begin
                  bt_cnt_q <= bt_cnt_q + 1'b1;
               end
            end
            PRESSED: begin
               bt_cnt_q <= '0;
               if (!btn_s) state_q <= RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
               if (btn_s) begin
                  state_q  <= PRESSED;
                  bt_cnt_q <= '0;
               end else if (release_evt) begin
                  state_q  <= IDLE;
                  bt_cnt_q <= '0;
                  btn_db_q <= 1'b0;
               end else begin
                  bt_cnt_q <= bt_cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef HOLD_MODE_EN
   assign sub_w    = btn_db_q;
   assign mode_evt = press_evt | release_evt;
`else
   logic sub_q;

   always_ff @(posedge CLK) begin
      if (RST)            sub_q <= 1'b0;
      else if (press_evt) sub_q <= ~sub_q;
   end

   assign sub_w    = sub_q;
   assign mode_evt = press_evt;
`endif

   logic upd_q;

   always_ff @(posedge CLK) begin
      if (RST) upd_q <= 1'b0;
      else     upd_q <= sw_commit | mode_evt;
   end

   assign io.A      = a_q;
   assign io.B      = b_q;
   assign io.sub    = sub_w;
   assign io.btn_db = btn_db_q;
   assign io.upd    = upd_q;
endmodule

// File: tb/tb_operand_input_ctrl.sv
// tb/tb_operand_input_ctrl.sv - scoreboard bench for operand_input_ctrl (DB_CYCLES=4, SYNC_STG=2)
module tb_operand_input_ctrl;
   import adder_io_pkg::*;

   localparam int N   = 5;
   localparam int DB  = 4;
   localparam int SS  = 2;
   localparam int LAT = SS + DB + 1;
`ifdef HOLD_MODE_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   typedef struct {
      int           cyc;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         sub;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   upd_cnt = 0;
   int   rise_cnt = 0;
   int   fall_cnt = 0;
   logic btn_db_prev = 1'b0;

   exp_t         sb_q[$];
   logic [N-1:0] exp_a = '0;
   logic [N-1:0] exp_b = '0;
   logic         exp_sub = 1'b0;

   operand_input_ctrl_if #(.N(N)) io ();

   operand_input_ctrl #(.N(N), .DB_CYCLES(DB), .SYNC_STG(SS)) dut (
      .CLK (CLK),
      .RST (RST),
      .io  (io)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push_exp();
      sb_q.push_back('{cyc: cyc + LAT, a: exp_a, b: exp_b, sub: exp_sub});
   endtask

   task automatic model_press();
      exp_sub = HOLD ? 1'b1 : ~exp_sub;
   endtask

   task automatic release_button();
      io.Button = 1'b0;
      if (HOLD) begin
         exp_sub = 1'b0;
         push_exp();
      end
   endtask

   always @(negedge CLK) begin
      if (!RST) begin
         if (io.upd) begin
            exp_t e;
            upd_cnt++;
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("upd_cycle", 32'(cyc), 32'(e.cyc));
               check("upd_A",     32'(io.A),   32'(e.a));
               check("upd_B",     32'(io.B),   32'(e.b));
               check("upd_sub",   32'(io.sub), 32'(e.sub));
            end
         end
         if (io.btn_db && !btn_db_prev) rise_cnt++;
         if (!io.btn_db && btn_db_prev) fall_cnt++;
      end
      btn_db_prev = io.btn_db;
   end

   initial begin
      int u0, r0, f0;

      // Reset with live inputs: outputs stay clear, then both paths debounce from scratch.
      RST = 1'b1;
      io.A_in = 5'h1F;
      io.B_in = 5'h00;
      io.Button = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("rst_A",      32'(io.A),      32'd0);
         check("rst_B",      32'(io.B),      32'd0);
         check("rst_sub",    32'(io.sub),    32'd0);
         check("rst_upd",    32'(io.upd),    32'd0);
         check("rst_btn_db", 32'(io.btn_db), 32'd0);
      end
      step(1);
      RST = 1'b0;
      exp_a = 5'h1F;
      model_press();
      push_exp();
      step(12);
      check("t1_A", 32'(io.A), 32'h1F);
      release_button();
      step(12);

      // Operand commit
      io.A_in = 5'b00111;
      io.B_in = 5'b11101;
      exp_a = 5'd7;
      exp_b = 5'b11101;
      push_exp();
      step(14);
      check("t2_A", 32'(io.A), 32'd7);
      check("t2_B", 32'(io.B), 32'h1D);

      // Switch bounce that settles back on the committed value
      u0 = upd_cnt;
      for (int i = 0; i < 10; i++) begin
         io.A_in[0] = ~io.A_in[0];
         step(2);
      end
      step(12);
      check("t3_A",   32'(io.A), 32'd7);
      check("t3_upd", 32'(upd_cnt - u0), 32'd0);

      // Button bounce, hold, release
      u0 = upd_cnt;
      r0 = rise_cnt;
      f0 = fall_cnt;
      io.Button = 1'b1;
      step(1);
      io.Button = 1'b0;
      step(1);
      io.Button = 1'b1;
      model_press();
      push_exp();
      step(10);
      release_button();
      step(14);
      check("t4_upd",  32'(upd_cnt - u0), HOLD ? 32'd2 : 32'd1);
      check("t4_rise", 32'(rise_cnt - r0), 32'd1);
      check("t4_fall", 32'(fall_cnt - f0), 32'd1);
      check("t4_sub",  32'(io.sub), 32'(exp_sub));

      // Simultaneous switch commit and mode change
      u0 = upd_cnt;
      io.B_in = 5'd5;
      io.Button = 1'b1;
      exp_b = 5'd5;
      model_press();
      push_exp();
      step(12);
      release_button();
      step(12);
      check("t5_upd", 32'(upd_cnt - u0), HOLD ? 32'd2 : 32'd1);
      check("t5_B",   32'(io.B), 32'd5);

      // Reset in the middle of a press debounce
      u0 = upd_cnt;
      io.Button = 1'b1;
      step(5);
      check("t6_state_pw", 32'(dut.state_q), 32'(PRESS_WAIT));
      check("t6_cnt2",     32'(dut.bt_cnt_q), 32'd2);
      RST = 1'b1;
      io.Button = 1'b0;
      io.A_in = '0;
      io.B_in = '0;
      exp_a = '0;
      exp_b = '0;
      exp_sub = 1'b0;
      step(2);
      check("t6_rst_sub", 32'(io.sub), 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      check("t6_state_idle", 32'(dut.state_q), 32'(IDLE));
      step(12);
      check("t6_sub", 32'(io.sub), 32'd0);
      check("t6_upd", 32'(upd_cnt - u0), 32'd0);
      check("t6_A",   32'(io.A), 32'd0);

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
